// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first subtractor built around one full-subtractor cell
// Produces diff, borrow, zero and signed-overflow flags WIDTH+1 cycles after start is accepted.

module fullsubtractor (
  output logic bout,
  output logic diff,
  input  logic a,
  input  logic b,
  input  logic bin
);
  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             overflow
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, d_sr, d_next;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             cell_bout, cell_diff;
  logic             accept, last;

  fullsubtractor u_cell (
    .bout (cell_bout),
    .diff (cell_diff),
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw)
  );

  assign accept = start && (state != S_RUN);
  assign last   = (state == S_RUN) && (cnt == CW'(WIDTH - 1));
  assign d_next = {cell_diff, d_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last)  state_nx = S_DONE;
      S_DONE:  state_nx = start ? S_RUN : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      d_sr       <= '0;
      brw        <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      d_sr <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (state == S_RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= d_next;
      brw  <= cell_bout;
      cnt  <= cnt + CW'(1);
      // On the final bit the shift-reg LSBs hold the operand sign bits.
      if (last) begin
        diff       <= d_next;
        borrow_out <= cell_bout;
        zero       <= (d_next == '0);
        overflow   <= (a_sr[0] != b_sr[0]) && (cell_diff != a_sr[0]);
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH=32 and WIDTH=8

module tb_serial_subtractor;
  logic        clk = 1'b0;
  logic        rst, start, start8;
  logic [31:0] a, b;
  logic [7:0]  a8, b8;
  logic        busy, done, borrow_out, zero, overflow;
  logic [31:0] diff;
  logic        busy8, done8, borrow_out8, zero8, overflow8;
  logic [7:0]  diff8;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        z;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff),
    .borrow_out(borrow_out), .zero(zero), .overflow(overflow)
  );

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8),
    .borrow_out(borrow_out8), .zero(zero8), .overflow(overflow8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int w);
    exp_t        e;
    logic [31:0] m;
    logic [31:0] xm, ym;
    m    = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    xm   = x & m;
    ym   = y & m;
    e.d  = (xm - ym) & m;
    e.bo = (xm < ym);
    e.z  = (e.d == 32'd0);
    e.ov = (xm[w-1] != ym[w-1]) && (e.d[w-1] != xm[w-1]);
    return e;
  endfunction

  task automatic launch(input bit sel, input logic [31:0] x, input logic [31:0] y);
    if (sel) begin
      a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1;
      sb.push_back(model(x, y, 8));
    end else begin
      a = x; b = y; start = 1'b1;
      sb.push_back(model(x, y, 32));
    end
    tick();
    start = 1'b0; start8 = 1'b0;
    a = $urandom; b = $urandom;
    a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic wait_done(input bit sel, input string name, input int elapsed, input int exp_lat);
    int          n;
    exp_t        e;
    logic [31:0] od;
    logic        obo, oz, oov, obusy;
    n = elapsed;
    while (((sel ? done8 : done) !== 1'b1) && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if ((sel ? done8 : done) !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done not seen after %0d cycles, required %0d", name, n, exp_lat);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    e     = sb.pop_front();
    od    = sel ? {24'h0, diff8} : diff;
    obo   = sel ? borrow_out8 : borrow_out;
    oz    = sel ? zero8 : zero;
    oov   = sel ? overflow8 : overflow;
    obusy = sel ? busy8 : busy;
    checks += 6;
    if (n !== exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d cycles, required %0d", name, n, exp_lat);
    end
    if (obusy !== 1'b0) begin
      errors++; $display("FAIL %s busy_at_done: got %b, required 0", name, obusy);
    end
    if (od !== e.d) begin
      errors++; $display("FAIL %s diff: got %h, required %h", name, od, e.d);
    end
    if (obo !== e.bo) begin
      errors++; $display("FAIL %s borrow_out: got %b, required %b", name, obo, e.bo);
    end
    if (oz !== e.z) begin
      errors++; $display("FAIL %s zero: got %b, required %b", name, oz, e.z);
    end
    if (oov !== e.ov) begin
      errors++; $display("FAIL %s overflow: got %b, required %b", name, oov, e.ov);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks += 2;
    if ({busy, done, diff, borrow_out, zero, overflow} !== 37'd0) begin
      errors++;
      $display("FAIL %s w32 outputs: got busy=%b done=%b diff=%h bo=%b z=%b ov=%b, required all 0",
               name, busy, done, diff, borrow_out, zero, overflow);
    end
    if ({busy8, done8, diff8, borrow_out8, zero8, overflow8} !== 13'd0) begin
      errors++;
      $display("FAIL %s w8 outputs: got busy=%b done=%b diff=%h bo=%b z=%b ov=%b, required all 0",
               name, busy8, done8, diff8, borrow_out8, zero8, overflow8);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    launch(1'b0, 32'd5, 32'd3);
    wait_done(1'b0, "sub_5_3", 1, 33);
    tick();
    checks += 2;
    if (done !== 1'b0) begin
      errors++; $display("FAIL done_pulse_width: got done=%b, required 0", done);
    end
    if (diff !== 32'd2) begin
      errors++; $display("FAIL diff_hold: got %h, required 00000002", diff);
    end
    launch(1'b0, 32'd3, 32'd5);
    wait_done(1'b0, "sub_3_5", 1, 33);
    tick();
    launch(1'b0, 32'h8000_0000, 32'd1);
    wait_done(1'b0, "ovf_neg", 1, 33);
    tick();
    launch(1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1'b0, "ovf_pos", 1, 33);
    tick();
  endtask

  task automatic test_back_to_back();
    launch(1'b0, 32'h1234_5678, 32'h1234_5678);
    wait_done(1'b0, "equal", 1, 33);
    launch(1'b0, 32'd0, 32'd1);
    wait_done(1'b0, "b2b_0_1", 1, 33);
    tick();
  endtask

  task automatic test_ignore_and_reset();
    int seen;
    launch(1'b0, 32'd10, 32'd4);
    repeat (3) tick();
    a = 32'd0; b = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(1'b0, "start_while_busy", 5, 33);
    tick();
    launch(1'b0, 32'd1, 32'd2);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check_all_zero("mid_op_reset");
    seen = 0;
    repeat (40) begin
      tick();
      if (done === 1'b1) seen = 1;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL abandoned_op_done: got done pulse, required none");
    end
  endtask

  task automatic test_random();
    logic [31:0] corners [5];
    logic [31:0] x, y;
    corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 1000; i++) begin
      if (i < 25) begin
        x = corners[i / 5];
        y = corners[i % 5];
      end else begin
        x = $urandom;
        y = $urandom;
      end
      launch(1'b0, x, y);
      wait_done(1'b0, $sformatf("rand32[%0d] %h-%h", i, x, y), 1, 33);
    end
    tick();
  endtask

  task automatic test_width8();
    logic [31:0] corners [5];
    logic [31:0] x, y;
    corners = '{32'h00, 32'h01, 32'h7F, 32'h80, 32'hFF};
    for (int i = 0; i < 300; i++) begin
      if (i < 25) begin
        x = corners[i / 5];
        y = corners[i % 5];
      end else begin
        x = $urandom_range(255, 0);
        y = $urandom_range(255, 0);
      end
      launch(1'b1, x, y);
      wait_done(1'b1, $sformatf("rand8[%0d] %h-%h", i, x[7:0], y[7:0]), 1, 9);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start8 = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_and_reset();
    test_random();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
